// File: rtl/br_arb_requester.sv
// Requester front end for br_arb_rr: per-requester 2-entry FIFOs drive `request`; the granted head is muxed onto pop.
// Latency: a push at cycle t raises request at t+1 and may dequeue at t+1; the pop path is combinational from grant/pop_ready.
// Backpressure: push_ready is a flop that drops when the FIFO is full; a request holds until its grant is taken with pop_ready.
// Optional: define BR_ARB_REQUESTER_STARVATION_EN to build the per-requester wait counters behind `starved`.
module br_arb_requester #(
    parameter int NumRequesters       = 2,
    parameter int Width               = 8,
    parameter int StarvationThreshold = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumRequesters-1:0]       push_valid,
    output logic [NumRequesters-1:0]       push_ready,
    input  logic [NumRequesters*Width-1:0] push_data,
    output logic [NumRequesters-1:0]       request,
    input  logic [NumRequesters-1:0]       grant,
    output logic                           enable_priority_update,
    output logic                           pop_valid,
    input  logic                           pop_ready,
    output logic [Width-1:0]               pop_data,
    output logic [NumRequesters-1:0]       starved
);

    logic [1:0]             count      [NumRequesters];
    logic [1:0]             count_next [NumRequesters];
    logic [NumRequesters-1:0] head;
    logic [NumRequesters-1:0] tail;
    logic [Width-1:0]       mem        [NumRequesters][2];
    logic [NumRequesters-1:0] push;
    logic [NumRequesters-1:0] deq;
    logic [NumRequesters-1:0] sel;

    // Handshakes and next occupancy; push+dequeue together leave the count unchanged.
    always_comb begin
        push = push_valid & push_ready;
        deq  = grant & request & {NumRequesters{pop_ready}};
        for (int i = 0; i < NumRequesters; i++) begin
            count_next[i] = count[i];
            if (push[i] && !deq[i]) begin
                count_next[i] = count[i] + 2'd1;
            end else if (!push[i] && deq[i]) begin
                count_next[i] = count[i] - 2'd1;
            end
        end
    end

    // Occupancy, pointers and push_ready; push_ready looks one cycle ahead so it never needs a comb path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRequesters; i++) begin
                count[i] <= 2'd0;
            end
            head       <= '0;
            tail       <= '0;
            push_ready <= '0;
        end else begin
            for (int i = 0; i < NumRequesters; i++) begin
                count[i]      <= count_next[i];
                push_ready[i] <= (count_next[i] < 2'd2);
                if (push[i]) begin
                    tail[i] <= ~tail[i];
                end
                if (deq[i]) begin
                    head[i] <= ~head[i];
                end
            end
        end
    end

    // Payload storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumRequesters; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= push_data[i*Width +: Width];
            end
        end
    end

    // Request is pure state, so it can only fall after a dequeue empties the FIFO.
    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            request[i] = (count[i] != 2'd0);
        end
    end

    // AND-OR mux of granted heads; yields zero when nothing valid is granted.
    always_comb begin
        sel                    = grant & request;
        pop_valid              = |sel;
        enable_priority_update = pop_ready;
        pop_data               = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (sel[i]) begin
                pop_data = pop_data | mem[i][head[i]];
            end
        end
    end

`ifdef BR_ARB_REQUESTER_STARVATION_EN
    localparam int WaitW = $clog2(StarvationThreshold + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(StarvationThreshold);

    logic [WaitW-1:0] wait_cnt  [NumRequesters];
    logic [WaitW-1:0] wait_next [NumRequesters];

    // Wait counter: counts cycles pending without a dequeue, clears on dequeue or idle, saturates at the threshold.
    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            wait_next[i] = wait_cnt[i];
            if (!request[i] || deq[i]) begin
                wait_next[i] = '0;
            end else if (wait_cnt[i] != WaitMax) begin
                wait_next[i] = wait_cnt[i] + 1'b1;
            end
        end
    end

    // Register counters and the starved flag together so starved has no comb input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRequesters; i++) begin
                wait_cnt[i] <= '0;
            end
            starved <= '0;
        end else begin
            for (int i = 0; i < NumRequesters; i++) begin
                wait_cnt[i] <= wait_next[i];
                starved[i]  <= (wait_next[i] == WaitMax);
            end
        end
    end
`else
    assign starved = '0;
`endif

`ifndef SYNTHESIS
    params_a: assert property (@(posedge clk)
        (NumRequesters >= 2) && (Width >= 1) && (StarvationThreshold >= 1));
    grant_onehot0_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
`endif

endmodule

// File: tb/tb_br_arb_requester.sv
// Bench for br_arb_requester: scoreboard queues filled on accepted pushes, drained and compared on dequeues.
// A passive negedge monitor checks request/push_ready/pop against the queue model every cycle.
// Directed phases: reset, single push, fill/hold, starvation, round-robin full rate, reset while full.
module tb_br_arb_requester;
    localparam int N = 2;
    localparam int W = 8;
    localparam int T = 4;
`ifdef BR_ARB_REQUESTER_STARVATION_EN
    localparam bit StarvEn = 1'b1;
`else
    localparam bit StarvEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   push_valid = '0;
    logic [N-1:0]   push_ready;
    logic [N*W-1:0] push_data = '0;
    logic [N-1:0]   request;
    logic [N-1:0]   grant;
    logic           enable_priority_update;
    logic           pop_valid;
    logic           pop_ready = 1'b0;
    logic [W-1:0]   pop_data;
    logic [N-1:0]   starved;

    logic [N-1:0]   man_grant = '0;
    logic           arb_rr = 1'b0;
    logic           rr_last = 1'b1;
    logic [N-1:0]   rr_grant;

    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;
    int last_src = -1;
    logic prst = 1'b1;

    typedef logic [W-1:0] dq_t[$];
    dq_t sb_q[N];

    br_arb_requester #(
        .NumRequesters(N),
        .Width(W),
        .StarvationThreshold(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_data(push_data),
        .request(request),
        .grant(grant),
        .enable_priority_update(enable_priority_update),
        .pop_valid(pop_valid),
        .pop_ready(pop_ready),
        .pop_data(pop_data),
        .starved(starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin arbiter standing in for br_arb_rr.
    always_comb begin
        rr_grant = '0;
        if (rr_last) begin
            if (request[0])      rr_grant = 2'b01;
            else if (request[1]) rr_grant = 2'b10;
        end else begin
            if (request[1])      rr_grant = 2'b10;
            else if (request[0]) rr_grant = 2'b01;
        end
    end
    assign grant = arb_rr ? rr_grant : man_grant;

    always @(posedge clk) begin
        if (rst) rr_last <= 1'b1;
        else if (enable_priority_update && |(grant & request)) rr_last <= grant[1];
    end

    // Passive monitor: compare against queue model, then apply this cycle's pushes and dequeues.
    always @(negedge clk) begin
        logic [N-1:0] exp_req;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] sel;
        int src;
        if (rst) begin
            for (int i = 0; i < N; i++) sb_q[i].delete();
            prst = 1'b1;
            last_src = -1;
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_req[i] = (sb_q[i].size() != 0);
                exp_rdy[i] = !prst && (sb_q[i].size() < 2);
            end
            chk("mon_request", request, exp_req);
            chk("mon_push_ready", push_ready, exp_rdy);
            sel = grant & exp_req;
            chk("mon_pop_valid", pop_valid, |sel);
            chk("mon_epu", enable_priority_update, pop_ready);
            src = -1;
            for (int i = 0; i < N; i++) if (sel[i]) src = i;
            if (src >= 0) chk("mon_pop_data", pop_data, sb_q[src][0]);
            else          chk("mon_pop_data_idle", pop_data, 0);
            if (src >= 0 && pop_ready) begin
                if (arb_rr && exp_req == 2'b11 && last_src >= 0)
                    chk("rr_alternate", src, 1 - last_src);
                void'(sb_q[src].pop_front());
                last_src = src;
                n_pop++;
            end
            for (int i = 0; i < N; i++)
                if (push_valid[i] && push_ready[i]) sb_q[i].push_back(push_data[i*W +: W]);
            prst = 1'b0;
        end
    end

    initial begin
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [N-1:0] acc;
        int accepted;
        int pops_before;

        // Reset and idle.
        rst = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_push_ready", push_ready, 0);
        chk("rst_request", request, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_starved", starved, 0);
        tick(); rst = 1'b0; #1;
        chk("rdy_first_cycle", push_ready, 0);
        tick(); #1;
        chk("rdy_second_cycle", push_ready, 2'b11);
        chk("idle_request", request, 0);

        // Single push, granted the next cycle.
        tick(); push_valid = 2'b01; push_data = {8'h00, 8'hA5};
        tick(); push_valid = 2'b00; man_grant = 2'b01; pop_ready = 1'b1; #1;
        chk("a5_pop_valid", pop_valid, 1);
        chk("a5_pop_data", pop_data, 8'hA5);
        tick(); man_grant = 2'b00; pop_ready = 1'b0; #1;
        chk("a5_request_drop", request[0], 0);

        // Fill requester 1, hold it granted but not ready, then drain.
        tick(); push_valid = 2'b10; push_data = {8'h11, 8'h00};
        tick(); push_data = {8'h22, 8'h00};
        tick(); push_valid = 2'b00; #1;
        chk("full_push_ready", push_ready[1], 0);
        for (int k = 0; k < 10; k++) begin
            tick(); man_grant = 2'b10; #1;
            chk("hold_request", request[1], 1);
            chk("hold_pop_valid", pop_valid, 1);
        end
        tick(); pop_ready = 1'b1; #1;
        chk("drain_first", pop_data, 8'h11);
        chk("full_deq_push_ready", push_ready[1], 0);
        tick(); #1;
        chk("drain_second", pop_data, 8'h22);
        chk("after_deq_push_ready", push_ready[1], 1);
        tick(); man_grant = 2'b00; pop_ready = 1'b0; #1;
        chk("drained_request", request[1], 0);

        // Starvation: requester 0 pending with no grant.
        tick(); push_valid = 2'b01; push_data = {8'h00, 8'h5A};
        for (int w = 1; w <= 7; w++) begin
            tick(); push_valid = 2'b00; #1;
            chk("starved_wait", starved[0], StarvEn && (w >= 5));
            chk("starved_other", starved[1], 0);
        end
        tick(); man_grant = 2'b01; pop_ready = 1'b1; #1;
        chk("starved_at_deq", starved[0], StarvEn);
        chk("starved_pop_data", pop_data, 8'h5A);
        tick(); man_grant = 2'b00; pop_ready = 1'b0; #1;
        chk("starved_cleared", starved[0], 0);

        // Both requesters at full rate under round-robin.
        d0 = 8'h00; d1 = 8'h80; acc = '0; accepted = 0;
        pops_before = n_pop;
        arb_rr = 1'b1; pop_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (acc[0]) d0 = d0 + 8'd1;
            if (acc[1]) d1 = d1 + 8'd1;
            push_valid = 2'b11;
            push_data = {d1, d0};
            #1;
            acc = push_valid & push_ready;
            accepted += int'(acc[0]) + int'(acc[1]);
        end
        tick(); push_valid = 2'b00;
        for (int c = 0; c < 20 && (sb_q[0].size() != 0 || sb_q[1].size() != 0); c++) tick();
        chk("rr_drain_q0", sb_q[0].size(), 0);
        chk("rr_drain_q1", sb_q[1].size(), 0);
        chk("rr_accepted", accepted >= 30, 1);
        chk("rr_pops_match", n_pop - pops_before, accepted);
        arb_rr = 1'b0; pop_ready = 1'b0; man_grant = 2'b00;

        // Reset while both FIFOs are full.
        tick(); push_valid = 2'b11; push_data = {8'h41, 8'h31};
        tick(); push_data = {8'h42, 8'h32};
        tick(); push_valid = 2'b00; #1;
        chk("full_both_request", request, 2'b11);
        chk("full_both_ready", push_ready, 2'b00);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; man_grant = 2'b01; pop_ready = 1'b1; #1;
        chk("midrst_request", request, 0);
        chk("midrst_pop_valid", pop_valid, 0);
        chk("midrst_pop_data", pop_data, 0);
        tick(); man_grant = 2'b00; pop_ready = 1'b0; push_valid = 2'b01; push_data = {8'h00, 8'h77};
        tick(); push_valid = 2'b00; man_grant = 2'b01; pop_ready = 1'b1; #1;
        chk("midrst_new_data", pop_data, 8'h77);
        tick(); man_grant = 2'b00; pop_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
